// File: rtl/io_input_controller.sv
// io_input_controller
// Input side of the board I/O path: synchronises and debounces the DE2
// switch/key pins, turns key presses into sticky events and answers
// single-cycle DMA read requests with a snapshot of the whole input state.
//
// Read handshake: rd_req is a one-cycle strobe with no back-pressure. Every
// cycle rd_req is sampled high produces exactly one rd_valid pulse on the
// following cycle, carrying the state as it was before any clear requested
// by rd_clr in that same cycle. rd_data holds until the next read.
module io_input_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        physical_clock,
  input  logic        reset,
  input  logic [21:0] IO_input,
  input  logic        rd_req,
  input  logic        rd_clr,
  output logic [17:0] sw_value,
  output logic [3:0]  key_level,
  output logic [3:0]  key_event,
  output logic [3:0]  overrun,
  output logic        event_pending,
  output logic [31:0] rd_data,
  output logic        rd_valid
);

  // Idle pin pattern: switches down (0), keys released (1, active-low pins).
  localparam logic [21:0]      PIN_IDLE = {4'hF, 18'h0};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [21:0]      sync1;
  logic [21:0]      sync2;
  logic [21:0]      stable;
  logic [CNT_W-1:0] cnt [22];
  logic [3:0]       key_level_d;
  logic [3:0]       press;
  logic             clr;

  // Two-flop synchroniser on every raw pin.
  always_ff @(posedge physical_clock) begin
    if (reset) begin
      sync1 <= PIN_IDLE;
      sync2 <= PIN_IDLE;
    end else begin
      sync1 <= IO_input;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: a new level is accepted only after it has differed from
  // the accepted level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge physical_clock) begin
    for (int i = 0; i < 22; i++) begin
      if (reset) begin
        cnt[i]    <= '0;
        stable[i] <= PIN_IDLE[i];
      end else if (stable[i] != sync2[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end else begin
        cnt[i] <= '0;
      end
    end
  end

  // Registered debounced levels; keys are inverted so 1 means pressed.
  always_ff @(posedge physical_clock) begin
    if (reset) begin
      sw_value    <= '0;
      key_level   <= '0;
      key_level_d <= '0;
    end else begin
      sw_value    <= stable[17:0];
      key_level   <= ~stable[21:18];
      key_level_d <= key_level;
    end
  end

  // Press edge detection and the read-with-clear qualifier.
  always_comb begin
    press = key_level & ~key_level_d;
    clr   = rd_req & rd_clr;
  end

  // Sticky events and overruns; a press coinciding with a clear keeps its
  // event and does not count as an overrun.
  always_ff @(posedge physical_clock) begin
    if (reset) begin
      key_event <= '0;
      overrun   <= '0;
    end else if (clr) begin
      key_event <= press;
      overrun   <= '0;
    end else begin
      key_event <= key_event | press;
      overrun   <= overrun | (press & key_event);
    end
  end

  // Read response: snapshot of pre-clear state, one pulse per request.
  always_ff @(posedge physical_clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) begin
        rd_data <= {2'b00, overrun, key_event, key_level, sw_value};
      end
    end
  end

  assign event_pending = |key_event;

endmodule

// File: tb/tb_io_input_controller.sv
// Bench for io_input_controller with a short debounce window. A behavioural
// model tracks the pins sample history and the sticky/read rules; every
// output is compared against it on each falling edge, read responses go
// through an expected queue, and directed scenarios add fixed checks.
module tb_io_input_controller;

  localparam int D = 4;
  localparam logic [21:0] IDLE = 22'h3C0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset  = 1'b1;
  logic [21:0] pins   = IDLE;
  logic        rd_req = 1'b0;
  logic        rd_clr = 1'b0;
  logic [17:0] sw_value;
  logic [3:0]  key_level, key_event, overrun;
  logic        event_pending;
  logic [31:0] rd_data;
  logic        rd_valid;

  io_input_controller #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .physical_clock(clk),
    .reset(reset),
    .IO_input(pins),
    .rd_req(rd_req),
    .rd_clr(rd_clr),
    .sw_value(sw_value),
    .key_level(key_level),
    .key_event(key_event),
    .overrun(overrun),
    .event_pending(event_pending),
    .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pins reach the debouncer two samples late; a level is accepted once the
  // last D synchronised samples all disagree with the accepted level.
  logic [21:0] m_s1, m_s2, m_stable;
  logic [21:0] hist[$];
  logic [17:0] m_sw;
  logic [3:0]  m_kl, m_kl_d, m_ev, m_ov;
  logic [31:0] m_rdd;
  logic        m_rdv;
  bit          model_live = 0;

  task automatic model_step();
    logic [3:0] pr;
    logic       c;
    bit         all_diff;
    if (reset) begin
      m_s1 = IDLE; m_s2 = IDLE; m_stable = IDLE;
      hist.delete();
      m_sw = '0; m_kl = '0; m_kl_d = '0; m_ev = '0; m_ov = '0;
      m_rdd = '0; m_rdv = 1'b0;
    end else begin
      pr = m_kl & ~m_kl_d;
      c  = rd_req & rd_clr;
      if (rd_req) begin
        m_rdd = {2'b00, m_ov, m_ev, m_kl, m_sw};
        exp_q.push_back(m_rdd);
      end
      m_rdv = rd_req;
      m_ov  = c ? 4'h0 : (m_ov | (pr & m_ev));
      m_ev  = c ? pr : (m_ev | pr);
      m_kl_d = m_kl;
      m_sw   = m_stable[17:0];
      m_kl   = ~m_stable[21:18];
      hist.push_back(m_s2);
      if (hist.size() > D) void'(hist.pop_front());
      if (hist.size() == D) begin
        for (int b = 0; b < 22; b++) begin
          all_diff = 1;
          foreach (hist[j]) if (hist[j][b] == m_stable[b]) all_diff = 0;
          if (all_diff) m_stable[b] = ~m_stable[b];
        end
      end
      m_s2 = m_s1;
      m_s1 = pins;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      model_live = 1;
    end
  end

  // ---------------- scoreboard ----------------
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (model_live) begin
        check("sw_value", 32'(sw_value), 32'(m_sw));
        check("key_level", 32'(key_level), 32'(m_kl));
        check("key_event", 32'(key_event), 32'(m_ev));
        check("overrun", 32'(overrun), 32'(m_ov));
        check("event_pending", 32'(event_pending), 32'(|m_ev));
        check("rd_valid", 32'(rd_valid), 32'(m_rdv));
        check("rd_data", rd_data, m_rdd);
        if (m_rdv && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rd_resp", rd_data, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input int k, input bit pressed);
    pins[18+k] = ~pressed;
  endtask

  task automatic do_read(input bit c);
    rd_req = 1'b1;
    rd_clr = c;
    tick(1);
    rd_req = 1'b0;
    rd_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    // reset held with pins toggling
    repeat (3) begin
      tick(1);
      pins = 22'($urandom);
      check("rst_rd_valid", 32'(rd_valid), 0);
      check("rst_sw", 32'(sw_value), 0);
      check("rst_ev", 32'(key_event), 0);
    end
    tick(1);
    reset = 1'b0;
    pins  = IDLE;
    tick(6);

    // switch change: exact latency, no event
    pins[3] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      if (i == 6) check("sw3_early", 32'(sw_value[3]), 0);
      if (i == 7) check("sw3_on", 32'(sw_value[3]), 1);
    end
    check("sw_no_event", 32'(key_event), 0);
    tick(3);

    // short key glitch is rejected
    set_key(0, 1);
    tick(3);
    set_key(0, 0);
    tick(10);
    check("glitch_level", 32'(key_level), 0);
    check("glitch_event", 32'(key_event), 0);

    // real press, then read with clear
    set_key(1, 1);
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (i == 6) check("k1_level_early", 32'(key_level), 0);
      if (i == 7) begin
        check("k1_level", 32'(key_level), 32'h2);
        check("k1_event_early", 32'(key_event), 0);
      end
      if (i == 8) begin
        check("k1_event", 32'(key_event), 32'h2);
        check("k1_pending", 32'(event_pending), 1);
      end
    end
    do_read(1);
    check("k1_rd_valid", 32'(rd_valid), 1);
    check("k1_rd_data", rd_data, 32'h0088_0008);
    check("k1_cleared", 32'(key_event), 0);
    tick(1);
    check("k1_valid_drop", 32'(rd_valid), 0);
    set_key(1, 0);
    tick(10);
    check("k1_release_no_event", 32'(key_event), 0);

    // two presses without a read -> overrun
    repeat (2) begin
      set_key(2, 1);
      tick(6);
      set_key(2, 0);
      tick(6);
    end
    tick(2);
    check("k2_overrun", 32'(overrun), 32'h4);
    check("k2_event", 32'(key_event), 32'h4);
    do_read(1);
    check("k2_rd_ovr_bit", 32'(rd_data[28]), 1);
    check("k2_rd_ev_bit", 32'(rd_data[24]), 1);
    check("k2_ev_clear", 32'(key_event), 0);
    check("k2_ovr_clear", 32'(overrun), 0);
    tick(4);

    // press edge in the same cycle as read+clear: set wins
    set_key(3, 1);
    tick(7);
    do_read(1);
    check("k3_snap_bit", 32'(rd_data[25]), 0);
    check("k3_event_kept", 32'(key_event[3]), 1);
    check("k3_no_overrun", 32'(overrun[3]), 0);
    set_key(3, 0);
    tick(8);

    // reset in the middle of a debounce; key held through reset
    set_key(0, 1);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("mid_rst_level", 32'(key_level), 0);
    check("mid_rst_sw", 32'(sw_value), 0);
    check("mid_rst_rd", rd_data, 0);
    reset = 1'b0;
    tick(6);
    check("held_level_early", 32'(key_level), 0);
    tick(6);
    check("held_level", 32'(key_level), 32'h1);
    check("held_event", 32'(key_event), 32'h1);
    set_key(0, 0);
    tick(8);

    // randomized traffic against the model
    repeat (2500) begin
      tick(1);
      if ($urandom_range(0, 5) == 0) begin
        idx = ($urandom_range(0, 1) == 0) ? int'($urandom_range(18, 21)) : int'($urandom_range(0, 17));
        pins[idx] = ~pins[idx];
      end
      rd_req = ($urandom_range(0, 3) == 0);
      rd_clr = 1'($urandom_range(0, 1));
      reset  = ($urandom_range(0, 299) == 0);
    end
    reset  = 1'b0;
    rd_req = 1'b0;
    rd_clr = 1'b0;
    tick(3);
    check("resp_queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
